// File: rtl/shared_dmem.sv
// Shared data memory for two cores: one round-robin grant per cycle, sync write / registered read.
// Ack, rdata and err arrive one cycle after grant; the losing core is stalled combinationally.
module shared_dmem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic        c0_read_en,
  input  logic        c0_write_en,
  output logic        c0_stall,
  output logic        c0_ready,
  output logic [31:0] c0_rdata,
  output logic        c0_err,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  input  logic        c1_read_en,
  input  logic        c1_write_en,
  output logic        c1_stall,
  output logic        c1_ready,
  output logic [31:0] c1_rdata,
  output logic        c1_err,
  output logic [15:0] conflict_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  req0, req1;
  logic                  grant0, grant1;
  logic                  last_grant;
  logic                  any_grant;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic                  sel_write;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] word;

  // last_grant = 1 means core 1 was served last, so core 0 wins the next conflict.
  always_comb begin
    req0     = c0_read_en | c0_write_en;
    req1     = c1_read_en | c1_write_en;
    grant0   = req0 & (~req1 | last_grant);
    grant1   = req1 & ~grant0;
    c0_stall = req0 & ~grant0;
    c1_stall = req1 & ~grant1;
  end

  always_comb begin
    any_grant = grant0 | grant1;
    sel_addr  = grant1 ? c1_addr     : c0_addr;
    sel_wdata = grant1 ? c1_wdata    : c0_wdata;
    sel_write = grant1 ? c1_write_en : c0_write_en;
    legal     = (sel_addr[1:0] == 2'b00) && (sel_addr[31:ADDR_WIDTH+2] == '0);
    word      = sel_addr[ADDR_WIDTH+1:2];
  end

  // Array is never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && any_grant && sel_write && legal) begin
      mem[word] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_ready       <= 1'b0;
      c1_ready       <= 1'b0;
      c0_err         <= 1'b0;
      c1_err         <= 1'b0;
      c0_rdata       <= '0;
      c1_rdata       <= '0;
      last_grant     <= 1'b1;
      conflict_count <= '0;
    end else begin
      c0_ready <= grant0;
      c1_ready <= grant1;
      c0_err   <= grant0 & ~legal;
      c1_err   <= grant1 & ~legal;

      // A legal write leaves rdata holding its previous load result.
      if (grant0 && !legal) begin
        c0_rdata <= '0;
      end else if (grant0 && !sel_write) begin
        c0_rdata <= mem[word];
      end

      if (grant1 && !legal) begin
        c1_rdata <= '0;
      end else if (grant1 && !sel_write) begin
        c1_rdata <= mem[word];
      end

      if (any_grant) begin
        last_grant <= grant1;
      end

      if (req0 && req1 && (conflict_count != 16'hFFFF)) begin
        conflict_count <= conflict_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_shared_dmem.sv
// Bench for shared_dmem: vector table through a one-deep scoreboard queue plus reset/contention sequences.
module tb_shared_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic        c0_read_en, c0_write_en, c1_read_en, c1_write_en;
  logic        c0_stall, c0_ready, c0_err, c1_stall, c1_ready, c1_err;
  logic [31:0] c0_rdata, c1_rdata;
  logic [15:0] conflict_count;

  always #5 clk = ~clk;

  shared_dmem #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_read_en(c0_read_en), .c0_write_en(c0_write_en),
    .c0_stall(c0_stall), .c0_ready(c0_ready), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_read_en(c1_read_en), .c1_write_en(c1_write_en),
    .c1_stall(c1_stall), .c1_ready(c1_ready), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .conflict_count(conflict_count)
  );

  localparam logic [1:0] NO = 2'd0;
  localparam logic [1:0] RD = 2'd1;
  localparam logic [1:0] WR = 2'd2;
  localparam logic [1:0] RW = 2'd3;

  // Two-bit expectation fields: bit 0 = core 0, bit 1 = core 1.
  typedef struct {
    logic [1:0]  op0;
    logic [31:0] a0, d0;
    logic [1:0]  op1;
    logic [31:0] a1, d1;
    logic [1:0]  stl, rdy, err, chk;
    logic [31:0] q0, q1;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  vec_t exp_q [$];
  vec_t v;

  int pass_cnt   = 0;
  int total_cnt  = 0;
  int model_conf = 0;
  int acks0      = 0;
  int acks1      = 0;
  int n0, n1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic drive(input vec_t x);
    c0_read_en  = x.op0[0];
    c0_write_en = x.op0[1];
    c0_addr     = x.a0;
    c0_wdata    = x.d0;
    c1_read_en  = x.op1[0];
    c1_write_en = x.op1[1];
    c1_addr     = x.a1;
    c1_wdata    = x.d1;
  endtask

  task automatic idle_inputs();
    vec_t z;
    z = '{NO, 32'h0, 32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};
    drive(z);
  endtask

  task automatic apply(input vec_t x);
    vec_t e;
    @(negedge clk);
    drive(x);
    #1;
    check_bit("c0_stall", c0_stall, x.stl[0]);
    check_bit("c1_stall", c1_stall, x.stl[1]);
    if (x.op0 != NO && x.op1 != NO) model_conf++;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (c0_ready) acks0++;
    if (c1_ready) acks1++;
    check_bit("c0_ready", c0_ready, e.rdy[0]);
    check_bit("c1_ready", c1_ready, e.rdy[1]);
    check_bit("c0_err", c0_err, e.err[0]);
    check_bit("c1_err", c1_err, e.err[1]);
    if (e.chk[0]) check_word("c0_rdata", c0_rdata, e.q0);
    if (e.chk[1]) check_word("c1_rdata", c1_rdata, e.q1);
  endtask

  task automatic check_cleared(input string tag);
    check_bit({tag, " c0_ready"}, c0_ready, 1'b0);
    check_bit({tag, " c1_ready"}, c1_ready, 1'b0);
    check_bit({tag, " c0_err"}, c0_err, 1'b0);
    check_bit({tag, " c1_err"}, c1_err, 1'b0);
    check_word({tag, " c0_rdata"}, c0_rdata, 32'h0);
    check_word({tag, " c1_rdata"}, c1_rdata, 32'h0);
    check_word({tag, " conflict_count"}, {16'h0, conflict_count}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check_cleared("reset");
    model_conf = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();

    tbl[0]  = '{WR, 32'h0,   32'h11110000, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{NO, 32'h0,   32'h0, WR, 32'hFFC, 32'h2222FFFF, 2'b00, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{RW, 32'h10,  32'hDEADBEEF, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[3]  = '{RD, 32'h10,  32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{RD, 32'h0,   32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01, 32'h11110000, 32'h0};
    tbl[5]  = '{RD, 32'h10,  32'h0, RD, 32'hFFC, 32'h0, 2'b01, 2'b10, 2'b00, 2'b10, 32'h0, 32'h2222FFFF};
    tbl[6]  = '{RD, 32'h10,  32'h0, WR, 32'h40, 32'h12345678, 2'b10, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{RD, 32'h40,  32'h0, WR, 32'h40, 32'h12345678, 2'b01, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[8]  = '{RD, 32'h40,  32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01, 32'h12345678, 32'h0};
    tbl[9]  = '{NO, 32'h0,   32'h0, RD, 32'h13, 32'h0, 2'b00, 2'b10, 2'b10, 2'b10, 32'h0, 32'h0};
    tbl[10] = '{NO, 32'h0,   32'h0, WR, 32'h1000, 32'hBADBADBA, 2'b00, 2'b10, 2'b10, 2'b10, 32'h0, 32'h0};
    tbl[11] = '{WR, 32'h12,  32'h55555555, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b01, 2'b01, 32'h0, 32'h0};
    tbl[12] = '{RD, 32'h0,   32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01, 32'h11110000, 32'h0};
    tbl[13] = '{NO, 32'h0,   32'h0, RD, 32'hFFC, 32'h0, 2'b00, 2'b10, 2'b00, 2'b10, 32'h0, 32'h2222FFFF};
    tbl[14] = '{RD, 32'h10,  32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[15] = '{NO, 32'h0,   32'h0, RD, 32'hFFFFFFFC, 32'h0, 2'b00, 2'b10, 2'b10, 2'b10, 32'h0, 32'h0};
    tbl[16] = '{NO, 32'h0,   32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};

    do_reset();
    for (int i = 0; i < NV; i++) apply(tbl[i]);
    check_word("c0_rdata_hold", c0_rdata, 32'hDEADBEEF);
    check_word("c1_rdata_hold", c1_rdata, 32'h0);
    check_word("conflict_table", {16'h0, conflict_count}, 32'(model_conf));

    // First conflict after reset goes to core 0; core 1 follows next cycle.
    do_reset();
    v = '{RD, 32'h10, 32'h0, RD, 32'h40, 32'h0, 2'b10, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    apply(v);
    check_word("conflict_first", {16'h0, conflict_count}, 32'd1);
    v = '{NO, 32'h0, 32'h0, RD, 32'h40, 32'h0, 2'b00, 2'b10, 2'b00, 2'b10, 32'h0, 32'h12345678};
    apply(v);

    // Sustained write contention: each core holds its request until served.
    do_reset();
    acks0 = 0;
    acks1 = 0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      v = '{WR, 32'h80 + 32'(4 * n0), 32'hC0DE0000 + 32'(n0),
            WR, 32'hC0 + 32'(4 * n1), 32'hC1DE0000 + 32'(n1),
            (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 2'b01 : 2'b10,
            2'b00, 2'b00, 32'h0, 32'h0};
      apply(v);
      if (i % 2 == 0) n0++;
      else n1++;
    end
    check_word("acks_core0", 32'(acks0), 32'd3);
    check_word("acks_core1", 32'(acks1), 32'd3);
    check_word("conflict_sustained", {16'h0, conflict_count}, 32'd6);
    for (int k = 0; k < 3; k++) begin
      v = '{RD, 32'h80 + 32'(4 * k), 32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b01,
            32'hC0DE0000 + 32'(k), 32'h0};
      apply(v);
      v = '{NO, 32'h0, 32'h0, RD, 32'hC0 + 32'(4 * k), 32'h0, 2'b00, 2'b10, 2'b00, 2'b10,
            32'h0, 32'hC1DE0000 + 32'(k)};
      apply(v);
    end

    // Reset lands between a granted read and its acknowledge.
    @(negedge clk);
    v = '{RD, 32'h10, 32'h0, NO, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};
    drive(v);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cleared("midflight");
    @(negedge clk);
    v = '{RD, 32'h10, 32'h0, RD, 32'h40, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};
    drive(v);
    #1;
    check_bit("rst c0_stall", c0_stall, 1'b0);
    check_bit("rst c1_stall", c1_stall, 1'b1);
    @(posedge clk);
    #1;
    check_cleared("held_reset");
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_conf = 0;
    exp_q.delete();
    v = '{RD, 32'h10, 32'h0, RD, 32'h40, 32'h0, 2'b10, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    apply(v);
    check_word("conflict_after_release", {16'h0, conflict_count}, 32'(model_conf));
    v = '{NO, 32'h0, 32'h0, RD, 32'h40, 32'h0, 2'b00, 2'b10, 2'b00, 2'b10, 32'h0, 32'h12345678};
    apply(v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
